// File: rtl/led_trace_buf.sv
// LED trace buffer: passes the debug probe to the LEDs, or captures a triggered
// history and lets the user browse it. Optional LED_TRACE_IDX_EN adds view_idx.
module led_trace_buf #(
    parameter int AW       = 4,
    parameter int POST_CNT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   probe,
    input  logic          sample_en,
    input  logic          arm,
    input  logic          disarm,
    input  logic [15:0]   trig_mask,
    input  logic [15:0]   trig_val,
    input  logic          btn_next,
    input  logic          btn_prev,
    output logic [15:0]   led_out,
    output logic [1:0]    state,
    output logic          trig_hit,
    output logic [AW:0]   fill_cnt
`ifdef LED_TRACE_IDX_EN
    ,
    output logic [AW-1:0] view_idx
`endif
);

    localparam int              DEPTH     = 1 << AW;
    localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   POST_INIT = AW'(POST_CNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_POST   = 2'b10,
        S_FROZEN = 2'b11
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_view_ptr, r_trig_ptr, r_post_cnt;
    logic [AW:0]   r_fill;
    logic          r_trig_hit, r_next_q, r_prev_q;
    logic [15:0]   r_led;

    logic          w_ctrl, w_wr, w_match, w_trig, w_post_done, w_entry, w_step;
    logic          w_next_e, w_prev_e;
    logic [AW-1:0] w_newest, w_oldest, w_trig_ptr_nxt;

    assign w_ctrl         = disarm | arm;
    assign w_wr           = sample_en & ~w_ctrl & ((r_state == S_ARMED) | (r_state == S_POST));
    assign w_match        = ((probe ^ trig_val) & trig_mask) == 16'h0000;
    assign w_trig         = w_wr & (r_state == S_ARMED) & w_match;
    assign w_post_done    = w_wr & (r_state == S_POST) & (r_post_cnt == AW'(1));
    assign w_newest       = r_wr_ptr - AW'(1);
    assign w_oldest       = (r_fill == FULL) ? r_wr_ptr : '0;
    assign w_next_e       = btn_next & ~r_next_q;
    assign w_prev_e       = btn_prev & ~r_prev_q;
    assign w_step         = (r_state == S_FROZEN) & ~w_ctrl;
    assign w_entry        = (w_state_nxt == S_FROZEN) & (r_state != S_FROZEN);
    // trigger and freeze can coincide when POST_CNT is zero
    assign w_trig_ptr_nxt = w_trig ? r_wr_ptr : r_trig_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (disarm) begin
            w_state_nxt = S_IDLE;
        end else if (arm) begin
            w_state_nxt = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED: if (w_trig)      w_state_nxt = (POST_CNT == 0) ? S_FROZEN : S_POST;
                S_POST:  if (w_post_done) w_state_nxt = S_FROZEN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= probe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_view_ptr <= '0;
            r_trig_ptr <= '0;
            r_post_cnt <= '0;
            r_fill     <= '0;
            r_trig_hit <= 1'b0;
            r_led      <= 16'h0000;
            r_next_q   <= 1'b0;
            r_prev_q   <= 1'b0;
        end else begin
            r_next_q <= btn_next;
            r_prev_q <= btn_prev;

            if (!disarm && arm) begin
                r_wr_ptr   <= '0;
                r_fill     <= '0;
                r_trig_hit <= 1'b0;
            end else if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_fill != FULL) r_fill <= r_fill + (AW+1)'(1);
            end

            if (w_trig) begin
                r_trig_ptr <= r_wr_ptr;
                r_trig_hit <= 1'b1;
                r_post_cnt <= POST_INIT;
            end else if (w_wr && r_state == S_POST) begin
                r_post_cnt <= r_post_cnt - AW'(1);
            end

            // simultaneous next/prev edges cancel out
            if (w_entry)
                r_view_ptr <= w_trig_ptr_nxt;
            else if (w_step && w_next_e && !w_prev_e && r_view_ptr != w_newest)
                r_view_ptr <= r_view_ptr + AW'(1);
            else if (w_step && w_prev_e && !w_next_e && r_view_ptr != w_oldest)
                r_view_ptr <= r_view_ptr - AW'(1);

            r_led <= (r_state == S_FROZEN) ? r_mem[r_view_ptr] : probe;
        end
    end

`ifdef LED_TRACE_IDX_EN
    logic [AW-1:0] r_view_idx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_view_idx <= '0;
        else     r_view_idx <= (r_state == S_FROZEN) ? (r_view_ptr - w_oldest) : '0;
    end
    assign view_idx = r_view_idx;
`endif

    assign led_out  = r_led;
    assign state    = r_state;
    assign trig_hit = r_trig_hit;
    assign fill_cnt = r_fill;

endmodule

// File: tb/tb_led_trace_buf.sv
// Scoreboard bench for led_trace_buf: expectations are queued as stimulus is
// driven and checked against the DUT after the relevant clock edge.
module tb_led_trace_buf;

    localparam int AW = 4;
    localparam int SEL_LED = 0, SEL_ST = 1, SEL_TRIG = 2, SEL_FILL = 3, SEL_IDX = 4;

    logic          clk = 1'b0;
    logic          rst, sample_en, arm, disarm, btn_next, btn_prev;
    logic [15:0]   probe, trig_mask, trig_val, led_out;
    logic [1:0]    state;
    logic          trig_hit;
    logic [AW:0]   fill_cnt;
`ifdef LED_TRACE_IDX_EN
    logic [AW-1:0] view_idx;
`endif

    led_trace_buf #(.AW(AW), .POST_CNT(8)) dut (
        .clk(clk), .rst(rst), .probe(probe), .sample_en(sample_en),
        .arm(arm), .disarm(disarm), .trig_mask(trig_mask), .trig_val(trig_val),
        .btn_next(btn_next), .btn_prev(btn_prev), .led_out(led_out),
        .state(state), .trig_hit(trig_hit), .fill_cnt(fill_cnt)
`ifdef LED_TRACE_IDX_EN
        , .view_idx(view_idx)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_LED:  return {16'h0, led_out};
            SEL_ST:   return {30'h0, state};
            SEL_TRIG: return {31'h0, trig_hit};
            SEL_FILL: return 32'(fill_cnt);
`ifdef LED_TRACE_IDX_EN
            SEL_IDX:  return 32'(view_idx);
`endif
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic do_sample(input logic [15:0] v);
        probe = v; sample_en = 1'b1; tick(); sample_en = 1'b0;
    endtask

    // press = rising edge on first clock, LED reflects the move one clock later
    task automatic press(input bit nxt);
        if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
        tick();
        btn_next = 1'b0; btn_prev = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; sample_en = 0; arm = 0; disarm = 0; btn_next = 0; btn_prev = 0;
        probe = 16'h0; trig_mask = 16'h0; trig_val = 16'h0;
        #2;
        expect_v("rst_state", SEL_ST, 0);
        expect_v("rst_led", SEL_LED, 0);
        expect_v("rst_trig", SEL_TRIG, 0);
        expect_v("rst_fill", SEL_FILL, 0);
        drain();
        tick(); tick();
        rst = 1'b0;

        // idle passthrough
        probe = 16'h1234;
        expect_v("idle_pass", SEL_LED, 16'h1234);
        tick(); drain();

        // test 1: trigger on 5th sample, freeze after 8 more
        trig_mask = 16'hFFFF; trig_val = 16'h0005;
        do_arm();
        expect_v("t1_armed", SEL_ST, 1);
        drain();
        for (int i = 1; i <= 4; i++) do_sample(16'(i));
        expect_v("t1_pretrig", SEL_TRIG, 0);
        drain();
        do_sample(16'h0005);
        expect_v("t1_trig", SEL_TRIG, 1);
        expect_v("t1_post", SEL_ST, 2);
        drain();
        for (int i = 6; i <= 12; i++) do_sample(16'(i));
        expect_v("t1_still_post", SEL_ST, 2);
        drain();
        do_sample(16'h000D);
        expect_v("t1_frozen", SEL_ST, 3);
        expect_v("t1_fill", SEL_FILL, 13);
        drain();
        probe = 16'hFFFF;
        tick();
        expect_v("t1_led_trig", SEL_LED, 16'h0005);
        drain();

        // test 2: browse with clamping at both ends
        for (int k = 1; k <= 9; k++) begin
            press(1'b1);
            expect_v("t2_next", SEL_LED, (5 + k > 13) ? 13 : 5 + k);
            drain();
        end
        for (int k = 1; k <= 13; k++) begin
            press(1'b0);
            expect_v("t2_prev", SEL_LED, (13 - k < 1) ? 1 : 13 - k);
            drain();
        end
        btn_next = 1'b1; btn_prev = 1'b1; tick();
        btn_next = 1'b0; btn_prev = 1'b0; tick();
        expect_v("t2_both", SEL_LED, 16'h0001);
        drain();

        // test 3: wrapped buffer
        trig_val = 16'h0020;
        do_arm();
        expect_v("t3_fill_clr", SEL_FILL, 0);
        expect_v("t3_trig_clr", SEL_TRIG, 0);
        drain();
        for (int i = 1; i <= 40; i++) do_sample(16'(i));
        expect_v("t3_frozen", SEL_ST, 3);
        expect_v("t3_fill", SEL_FILL, 16);
        drain();
        tick();
        expect_v("t3_led_trig", SEL_LED, 16'h0020);
        drain();
        for (int k = 1; k <= 8; k++) begin
            press(1'b0);
            expect_v("t3_prev", SEL_LED, (32 - k < 25) ? 25 : 32 - k);
            drain();
        end
`ifdef LED_TRACE_IDX_EN
        expect_v("t3_idx_oldest", SEL_IDX, 0);
        drain();
`endif
        for (int k = 1; k <= 16; k++) begin
            press(1'b1);
            expect_v("t3_next", SEL_LED, (25 + k > 40) ? 40 : 25 + k);
            drain();
        end
`ifdef LED_TRACE_IDX_EN
        expect_v("t3_idx_newest", SEL_IDX, 15);
        drain();
`endif

        // test 4: partial mask
        trig_mask = 16'hFF00; trig_val = 16'hAB00;
        do_arm();
        do_sample(16'h12AB);
        expect_v("t4_nohit", SEL_TRIG, 0);
        expect_v("t4_armed", SEL_ST, 1);
        drain();
        do_sample(16'hAB37);
        expect_v("t4_hit", SEL_TRIG, 1);
        expect_v("t4_post", SEL_ST, 2);
        drain();

        // test 5: disarm beats arm; idle ignores samples
        arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
        expect_v("t5_idle", SEL_ST, 0);
        drain();
        for (int i = 0; i < 3; i++) do_sample(16'h7777);
        expect_v("t5_fill_keep", SEL_FILL, 2);
        drain();
        probe = 16'h5A5A;
        expect_v("t5_pass", SEL_LED, 16'h5A5A);
        tick(); drain();

        // test 6: async reset mid-POST
        trig_mask = 16'hFFFF; trig_val = 16'h0005;
        do_arm();
        for (int i = 1; i <= 10; i++) do_sample(16'(i));
        expect_v("t6_post", SEL_ST, 2);
        drain();
        #2 rst = 1'b1;
        #1;
        expect_v("t6_rst_state", SEL_ST, 0);
        expect_v("t6_rst_trig", SEL_TRIG, 0);
        expect_v("t6_rst_fill", SEL_FILL, 0);
        expect_v("t6_rst_led", SEL_LED, 0);
        drain();
        tick();
        rst = 1'b0;
        do_arm();
        do_sample(16'h0005);
        expect_v("t6_re_post", SEL_ST, 2);
        expect_v("t6_re_fill", SEL_FILL, 1);
        expect_v("t6_re_trig", SEL_TRIG, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
